denetim_durum_birimi: RTL and testbench
=======================================

# denetim_durum_birimi

Pipeline control unit (DDB) for the four-stage GETIR → COZ → YURUT → GERIYAZ core. It generates the stall (`durdur`) and flush (`bosalt`) controls for every stage, and the operand-forwarding selects consumed by `coz_yazmacoku`. It sequences three cases: load-use hazards, multi-cycle YURUT operations (divide, memory, convolution) and taken-branch flushes. A flush that arrives while instruction fetch is still outstanding is held pending until the fetch completes. It also keeps stall and flush performance counters.

## Interface
- `SAYAC_BIT`, 32, width of the performance counters.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `cyo_rs1_adres_i`  in  5  rs1 of the instruction in COZ.
- `cyo_rs2_adres_i`  in  5  rs2 of the instruction in COZ.
- `cyo_rs1_kullan_i`  in  1  COZ instruction reads rs1.
- `cyo_rs2_kullan_i`  in  1  COZ instruction reads rs2.
- `yrt_rd_adres_i`  in  5  rd of the instruction in YURUT.
- `yrt_yaz_yazmac_i`  in  1  YURUT instruction writes rd.
- `yrt_bellek_oku_i`  in  1  YURUT instruction is a load; its data is available only from GERIYAZ.
- `yrt_mesgul_i`  in  1  YURUT multi-cycle unit is busy.
- `yrt_dallanma_i`  in  1  branch/jump in YURUT redirects the PC this cycle.
- `gy_rd_adres_i`  in  5  rd in GERIYAZ.
- `gy_yaz_yazmac_i`  in  1  GERIYAZ writes rd.
- `gtr_mesgul_i`  in  1  GETIR has an instruction-memory request outstanding.
- `gtr_durdur_o`  out  1  hold PC and the GETIR output register.
- `cyo_durdur_o`  out  1  hold the COZ input.
- `cyo_bosalt_o`  out  1  replace the COZ output with NOP.
- `yrt_durdur_o`  out  1  hold YURUT.
- `yrt_bosalt_o`  out  1  replace the YURUT output with NOP.
- `gy_bosalt_o`  out  1  suppress the GERIYAZ register write.
- `cyo_yonlendir_kontrol1_o`  out  2  rs1 select: 00 register file, 01 YURUT result, 10 GERIYAZ value.
- `cyo_yonlendir_kontrol2_o`  out  2  rs2 select, same encoding.
- `durdurma_sayac_o`  out  SAYAC_BIT  number of cycles with `gtr_durdur_o`=1.
- `bosaltma_sayac_o`  out  SAYAC_BIT  number of accepted branch flushes.

## Operation
- Helper terms:
  - `eslesY(rs)` = `yrt_yaz_yazmac_i` & `yrt_rd_adres_i`≠0 & `yrt_rd_adres_i`==rs.
  - `eslesG(rs)` likewise, using the GERIYAZ inputs.
  - `yuk_kull` = `yrt_bellek_oku_i` & ((`cyo_rs1_kullan_i` & `eslesY(rs1)`) | (`cyo_rs2_kullan_i` & `eslesY(rs2)`)).
- Forwarding (combinational, per operand):
  - 01 if `eslesY` & !`yrt_bellek_oku_i`;
  - else 10 if `eslesG`;
  - else 00.
  - The YURUT match has priority over the GERIYAZ match. x0 never forwards.
- FSM state CALIS; outputs default to 0 and are evaluated in this priority order:
  1. `yrt_mesgul_i`: `gtr_durdur_o`, `cyo_durdur_o`, `yrt_durdur_o` and `gy_bosalt_o` = 1. `yrt_dallanma_i` and `yuk_kull` are ignored this cycle.
  2. `yrt_dallanma_i`: `cyo_bosalt_o` = `yrt_bosalt_o` = 1, and `bosaltma_sayac_o` increments. Next state is BOSALT_BEKLE if `gtr_mesgul_i`=1, otherwise CALIS.
  3. `yuk_kull`: `gtr_durdur_o` = `cyo_durdur_o` = `yrt_bosalt_o` = 1, inserting a single bubble. On the next cycle the load is in GERIYAZ and forwarding selects 10.
- FSM state BOSALT_BEKLE:
  - `cyo_bosalt_o`=1 every cycle.
  - `yrt_dallanma_i` and `yuk_kull` are ignored; YURUT holds only bubbles.
  - When `gtr_mesgul_i`=0, `cyo_bosalt_o` is still 1 that cycle (it discards the wrong-path fetch) and the next state is CALIS.
- Counters:
  - `durdurma_sayac_o` increments on every cycle with `gtr_durdur_o`=1.
  - Both counters wrap modulo 2^SAYAC_BIT.
- Reset (asynchronous):
  - state returns to CALIS; both counters clear to 0;
  - while `rst_i`=1: all `durdur` outputs = 0, all `bosalt` outputs = 1, forwarding selects = 00.
  - Reset asserted mid-BOSALT_BEKLE abandons the pending flush immediately.

## Timing
- All control and forwarding outputs are combinational from the current inputs and the state register: zero-cycle latency, valid before the clock edge at which the stages sample them.
- A load-use hazard costs exactly one stall cycle, provided memory is not busy.
- A branch flush lasts one cycle in CALIS, or 1 + N cycles when the fetch is outstanding for N cycles at the time of the branch.
- State and counters update on `clk_i` rising edge; counter outputs lag the triggering cycle by one cycle.
- Simultaneous `yrt_mesgul_i` and `yrt_dallanma_i`: busy wins. The branch is taken when busy drops, because YURUT re-presents it.

## Test plan
- Forwarding:
  - rs1=5, rs2=5 used; YURUT rd=5 write, not a load; GERIYAZ rd=5 write → both selects 01, no stall.
  - With YURUT rd=0 instead → both selects 10.
- Load-use: load in YURUT with rd=7, COZ rs2=7 used → `gtr_durdur_o`, `cyo_durdur_o`, `yrt_bosalt_o` = 1 for one cycle. Next cycle, with GERIYAZ rd=7 → select2=10 and no stall; `durdurma_sayac_o`=1.
- Multi-cycle: `yrt_mesgul_i` high 34 cycles with a coincident load-use hazard → four hold/suppress outputs = 1 for 34 cycles and `yrt_bosalt_o`=0. The load-use stall follows afterwards; `durdurma_sayac_o`=35.
- Branch with fetch idle → `cyo_bosalt_o` = `yrt_bosalt_o` = 1 for one cycle, state stays CALIS, `bosaltma_sayac_o`=1.
- Branch with `gtr_mesgul_i` high for 3 more cycles → `cyo_bosalt_o`=1 for 4 cycles, a second branch pulse during that window is ignored, `bosaltma_sayac_o`=1.
- Reset asserted during BOSALT_BEKLE → immediate CALIS, counters 0, all `bosalt` outputs=1 while reset is held.

Source files
------------

// File: rtl/denetim_durum_birimi.sv
// Pipeline control unit for the GETIR/COZ/YURUT/GERIYAZ core: stall, flush,
// operand-forwarding selects and stall/flush performance counters.
module denetim_durum_birimi #(
  parameter int SAYAC_BIT = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [4:0]           cyo_rs1_adres_i,
  input  logic [4:0]           cyo_rs2_adres_i,
  input  logic                 cyo_rs1_kullan_i,
  input  logic                 cyo_rs2_kullan_i,
  input  logic [4:0]           yrt_rd_adres_i,
  input  logic                 yrt_yaz_yazmac_i,
  input  logic                 yrt_bellek_oku_i,
  input  logic                 yrt_mesgul_i,
  input  logic                 yrt_dallanma_i,
  input  logic [4:0]           gy_rd_adres_i,
  input  logic                 gy_yaz_yazmac_i,
  input  logic                 gtr_mesgul_i,
  output logic                 gtr_durdur_o,
  output logic                 cyo_durdur_o,
  output logic                 cyo_bosalt_o,
  output logic                 yrt_durdur_o,
  output logic                 yrt_bosalt_o,
  output logic                 gy_bosalt_o,
  output logic [1:0]           cyo_yonlendir_kontrol1_o,
  output logic [1:0]           cyo_yonlendir_kontrol2_o,
  output logic [SAYAC_BIT-1:0] durdurma_sayac_o,
  output logic [SAYAC_BIT-1:0] bosaltma_sayac_o
);

  typedef enum logic [0:0] {
    CALIS        = 1'b0,
    BOSALT_BEKLE = 1'b1
  } durum_t;

  localparam logic [SAYAC_BIT-1:0] BIR = {{(SAYAC_BIT-1){1'b0}}, 1'b1};

  durum_t durum;
  durum_t durum_sonraki;
  logic   dallanma_kabul;

  logic esY1, esY2, esG1, esG2;
  logic yuk_kull;

  // x0 is hard-wired zero, so a write to it never creates a dependency.
  function automatic logic esles(input logic yaz, input logic [4:0] rd,
                                 input logic [4:0] rs);
    return yaz && (rd != 5'd0) && (rd == rs);
  endfunction

  // A load in YURUT has no data yet, so it falls through to GERIYAZ or the file.
  function automatic logic [1:0] yonlendir(input logic es_yrt, input logic es_gy,
                                           input logic bellek_oku);
    if (es_yrt && !bellek_oku) return 2'b01;
    else if (es_gy)            return 2'b10;
    else                       return 2'b00;
  endfunction

  assign esY1 = esles(yrt_yaz_yazmac_i, yrt_rd_adres_i, cyo_rs1_adres_i);
  assign esY2 = esles(yrt_yaz_yazmac_i, yrt_rd_adres_i, cyo_rs2_adres_i);
  assign esG1 = esles(gy_yaz_yazmac_i, gy_rd_adres_i, cyo_rs1_adres_i);
  assign esG2 = esles(gy_yaz_yazmac_i, gy_rd_adres_i, cyo_rs2_adres_i);

  assign yuk_kull = yrt_bellek_oku_i &&
                    ((cyo_rs1_kullan_i && esY1) || (cyo_rs2_kullan_i && esY2));

  always_comb begin
    gtr_durdur_o             = 1'b0;
    cyo_durdur_o             = 1'b0;
    cyo_bosalt_o             = 1'b0;
    yrt_durdur_o             = 1'b0;
    yrt_bosalt_o             = 1'b0;
    gy_bosalt_o              = 1'b0;
    cyo_yonlendir_kontrol1_o = 2'b00;
    cyo_yonlendir_kontrol2_o = 2'b00;
    dallanma_kabul           = 1'b0;
    durum_sonraki            = durum;

    if (rst_i) begin
      cyo_bosalt_o  = 1'b1;
      yrt_bosalt_o  = 1'b1;
      gy_bosalt_o   = 1'b1;
      durum_sonraki = CALIS;
    end else begin
      cyo_yonlendir_kontrol1_o = yonlendir(esY1, esG1, yrt_bellek_oku_i);
      cyo_yonlendir_kontrol2_o = yonlendir(esY2, esG2, yrt_bellek_oku_i);

      unique case (durum)
        CALIS: begin
          if (yrt_mesgul_i) begin
            // Busy unit wins; YURUT re-presents any branch once it finishes.
            gtr_durdur_o = 1'b1;
            cyo_durdur_o = 1'b1;
            yrt_durdur_o = 1'b1;
            gy_bosalt_o  = 1'b1;
          end else if (yrt_dallanma_i) begin
            cyo_bosalt_o   = 1'b1;
            yrt_bosalt_o   = 1'b1;
            dallanma_kabul = 1'b1;
            if (gtr_mesgul_i) durum_sonraki = BOSALT_BEKLE;
          end else if (yuk_kull) begin
            gtr_durdur_o = 1'b1;
            cyo_durdur_o = 1'b1;
            yrt_bosalt_o = 1'b1;
          end
        end
        BOSALT_BEKLE: begin
          // The fetch completing this cycle is wrong-path and is discarded too.
          cyo_bosalt_o = 1'b1;
          if (!gtr_mesgul_i) durum_sonraki = CALIS;
        end
        default: durum_sonraki = CALIS;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum            <= CALIS;
      durdurma_sayac_o <= '0;
      bosaltma_sayac_o <= '0;
    end else begin
      durum <= durum_sonraki;
      if (gtr_durdur_o)   durdurma_sayac_o <= durdurma_sayac_o + BIR;
      if (dallanma_kabul) bosaltma_sayac_o <= bosaltma_sayac_o + BIR;
    end
  end

endmodule

// File: tb/tb_denetim_durum_birimi.sv
// Directed bench for denetim_durum_birimi: forwarding, load-use, multi-cycle
// stall, branch flush (idle and pending fetch) and asynchronous reset.
module tb_denetim_durum_birimi;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, yrd, grd;
  logic        rs1_k, rs2_k, yyaz, yoku, ymes, ydal, gyaz, gmes;
  logic        gtr_d, cyo_d, cyo_b, yrt_d, yrt_b, gy_b;
  logic [1:0]  fw1, fw2;
  logic [31:0] dsay, bsay;
  logic [5:0]  ctl;

  int tests = 0;
  int fails = 0;

  assign ctl = {gtr_d, cyo_d, yrt_d, cyo_b, yrt_b, gy_b};

  always #5 clk = ~clk;

  denetim_durum_birimi #(.SAYAC_BIT(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .cyo_rs1_adres_i(rs1), .cyo_rs2_adres_i(rs2),
    .cyo_rs1_kullan_i(rs1_k), .cyo_rs2_kullan_i(rs2_k),
    .yrt_rd_adres_i(yrd), .yrt_yaz_yazmac_i(yyaz), .yrt_bellek_oku_i(yoku),
    .yrt_mesgul_i(ymes), .yrt_dallanma_i(ydal),
    .gy_rd_adres_i(grd), .gy_yaz_yazmac_i(gyaz), .gtr_mesgul_i(gmes),
    .gtr_durdur_o(gtr_d), .cyo_durdur_o(cyo_d), .cyo_bosalt_o(cyo_b),
    .yrt_durdur_o(yrt_d), .yrt_bosalt_o(yrt_b), .gy_bosalt_o(gy_b),
    .cyo_yonlendir_kontrol1_o(fw1), .cyo_yonlendir_kontrol2_o(fw2),
    .durdurma_sayac_o(dsay), .bosaltma_sayac_o(bsay)
  );

  // ctl bit order: {gtr_durdur, cyo_durdur, yrt_durdur, cyo_bosalt, yrt_bosalt, gy_bosalt}

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; yrd = 5'd0; grd = 5'd0;
    rs1_k = 1'b0; rs2_k = 1'b0; yyaz = 1'b0; yoku = 1'b0;
    ymes = 1'b0; ydal = 1'b0; gyaz = 1'b0; gmes = 1'b0;
  endtask

  // Leaves the bench just after a rising edge, with reset released.
  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    rs1 = 5'd5; rs2 = 5'd5; rs1_k = 1'b1; rs2_k = 1'b1;
    yrd = 5'd5; yyaz = 1'b1; ymes = 1'b1;
    #2;
    tests++; if (ctl !== 6'b000111) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl, 6'b000111); end
    tests++; if ({fw1, fw2} !== 4'b0000) begin fails++; $display("FAIL reset_fwd got %b want 0000", {fw1, fw2}); end
    tests++; if (dsay !== 32'd0 || bsay !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", dsay, bsay); end
    do_reset();
  endtask

  task automatic test_forwarding();
    do_reset();
    rs1 = 5'd5; rs2 = 5'd5; rs1_k = 1'b1; rs2_k = 1'b1;
    yrd = 5'd5; yyaz = 1'b1; grd = 5'd5; gyaz = 1'b1;
    @(negedge clk);
    tests++; if ({fw1, fw2} !== 4'b0101) begin fails++; $display("FAIL fwd_yrt got %b want 0101", {fw1, fw2}); end
    tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL fwd_nostall got %b want 000000", ctl); end
    yrd = 5'd0; #1;
    tests++; if ({fw1, fw2} !== 4'b1010) begin fails++; $display("FAIL fwd_gy got %b want 1010", {fw1, fw2}); end
    grd = 5'd0; #1;
    tests++; if ({fw1, fw2} !== 4'b0000) begin fails++; $display("FAIL fwd_x0 got %b want 0000", {fw1, fw2}); end
    rs1 = 5'd9; grd = 5'd5; yrd = 5'd9; #1;
    tests++; if ({fw1, fw2} !== 4'b0110) begin fails++; $display("FAIL fwd_mixed got %b want 0110", {fw1, fw2}); end
  endtask

  task automatic test_load_use();
    do_reset();
    rs1 = 5'd3; rs2 = 5'd7; rs1_k = 1'b1; rs2_k = 1'b1;
    yrd = 5'd7; yyaz = 1'b1; yoku = 1'b1;
    @(negedge clk);
    tests++; if (ctl !== 6'b110010) begin fails++; $display("FAIL lu_stall got %b want 110010", ctl); end
    tests++; if (fw2 !== 2'b00) begin fails++; $display("FAIL lu_nofwd got %b want 00", fw2); end
    step();
    yyaz = 1'b0; yoku = 1'b0; yrd = 5'd0; grd = 5'd7; gyaz = 1'b1;
    @(negedge clk);
    tests++; if (fw2 !== 2'b10 || ctl !== 6'b000000) begin fails++; $display("FAIL lu_after got fw2=%b ctl=%b want 10/000000", fw2, ctl); end
    tests++; if (dsay !== 32'd1) begin fails++; $display("FAIL lu_cnt got %0d want 1", dsay); end
  endtask

  task automatic test_multicycle();
    do_reset();
    rs1 = 5'd4; rs1_k = 1'b1; yrd = 5'd4; yyaz = 1'b1; yoku = 1'b1; ymes = 1'b1;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      tests++; if (ctl !== 6'b111001) begin fails++; $display("FAIL busy_ctl cyc %0d got %b want 111001", i, ctl); end
      step();
    end
    ymes = 1'b0;
    @(negedge clk);
    tests++; if (ctl !== 6'b110010) begin fails++; $display("FAIL busy_then_lu got %b want 110010", ctl); end
    step();
    idle();
    @(negedge clk);
    tests++; if (dsay !== 32'd35) begin fails++; $display("FAIL busy_cnt got %0d want 35", dsay); end
  endtask

  task automatic test_branch_idle();
    do_reset();
    ydal = 1'b1; rs1 = 5'd2; rs1_k = 1'b1; yrd = 5'd2; yyaz = 1'b1; yoku = 1'b1;
    @(negedge clk);
    tests++; if (ctl !== 6'b000110) begin fails++; $display("FAIL br_flush got %b want 000110", ctl); end
    step();
    idle();
    @(negedge clk);
    tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL br_calis got %b want 000000", ctl); end
    tests++; if (bsay !== 32'd1) begin fails++; $display("FAIL br_cnt got %0d want 1", bsay); end
  endtask

  task automatic test_branch_pending();
    logic [5:0] want [4];
    logic [3:0] dal_seq, gm_seq;
    want[0] = 6'b000110; want[1] = 6'b000100; want[2] = 6'b000100; want[3] = 6'b000100;
    dal_seq = 4'b0101;   // bit i = branch pulse in cycle i
    gm_seq  = 4'b0111;   // fetch outstanding in cycles 0..2
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ydal = dal_seq[i]; gmes = gm_seq[i];
      @(negedge clk);
      tests++; if (ctl !== want[i]) begin fails++; $display("FAIL pend_ctl cyc %0d got %b want %b", i, ctl, want[i]); end
      step();
    end
    idle();
    @(negedge clk);
    tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL pend_done got %b want 000000", ctl); end
    tests++; if (bsay !== 32'd1) begin fails++; $display("FAIL pend_cnt got %0d want 1", bsay); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ydal = 1'b1; gmes = 1'b1;
    step();
    ydal = 1'b0;
    @(negedge clk);
    tests++; if (ctl !== 6'b000100 || bsay !== 32'd1) begin fails++; $display("FAIL rmid_pre got ctl=%b cnt=%0d want 000100/1", ctl, bsay); end
    #1 rst = 1'b1; ymes = 1'b1;
    #1;
    tests++; if (ctl !== 6'b000111) begin fails++; $display("FAIL rmid_ctl got %b want 000111", ctl); end
    tests++; if (dsay !== 32'd0 || bsay !== 32'd0) begin fails++; $display("FAIL rmid_cnt got %0d/%0d want 0/0", dsay, bsay); end
    @(posedge clk); #1;
    tests++; if (ctl !== 6'b000111) begin fails++; $display("FAIL rmid_held got %b want 000111", ctl); end
    ymes = 1'b0;
    #1 rst = 1'b0;
    #1;
    tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL rmid_calis got %b want 000000", ctl); end
    idle();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle();
    test_branch_idle();
    test_branch_pending();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
